// File: rtl/board_mem_slave_if.sv
// Wishbone classic-cycle link between a board-memory master (game logic or
// display) and the board_mem_slave responder.
//
// Signals (names follow the master's point of view, as in the Wishbone spec):
//   ADR_O  master -> slave  cell address, row*16 + col
//   DAT_O  master -> slave  write data
//   WE_O   master -> slave  1 = write, 0 = read
//   STB_O  master -> slave  strobe
//   CYC_O  master -> slave  bus cycle valid
//   DAT_I  slave -> master  read data
//   ACK_I  slave -> master  acknowledge
interface board_mem_slave_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic [ADDR_W-1:0] ADR_O;
   logic [DATA_W-1:0] DAT_O;
   logic              WE_O;
   logic              STB_O;
   logic              CYC_O;
   logic [DATA_W-1:0] DAT_I;
   logic              ACK_I;

   modport master (
      output ADR_O, DAT_O, WE_O, STB_O, CYC_O,
      input  DAT_I, ACK_I
   );

   modport slave (
      input  ADR_O, DAT_O, WE_O, STB_O, CYC_O,
      output DAT_I, ACK_I
   );
endinterface

// File: rtl/board_mem_slave.sv
// Minesweeper board memory: a 16x16 grid of 8-bit tile cells behind a
// Wishbone classic-cycle slave port. A built-in clear engine fills every
// cell with INIT_VAL after reset and whenever clear_req is pulsed while the
// bus is idle; bus requests stall while it runs.
//
// Ports:
//   CLK_I      clock
//   RST_I      asynchronous, active-high reset
//   bus        Wishbone slave side (ADR_O/DAT_O/WE_O/STB_O/CYC_O in,
//              DAT_I/ACK_I out)
//   clear_req  single-cycle pulse requesting a full board clear
//   busy       high while the clear engine is sweeping the memory
module board_mem_slave #(
   parameter int              ADDR_W   = 8,
   parameter int              DATA_W   = 8,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input  logic                    CLK_I,
   input  logic                    RST_I,
   board_mem_slave_if.slave        bus,
   input  logic                    clear_req,
   output logic                    busy
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      IDLE  = 2'd1,
      ACK   = 2'd2
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [ADDR_W-1:0]   clear_cnt;
   logic [ADDR_W-1:0]   clear_cnt_next;
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_addr;
   logic [DATA_W-1:0]   mem_wdata;
   logic                rd_en;
   logic [DATA_W-1:0]   rd_data;
   logic [DATA_W-1:0]   mem [DEPTH];

   // Control registers: FSM state, clear sweep pointer and the read-data
   // holding register. Reset drops us into CLEAR at cell 0 so the board is
   // always swept before the first bus access. rd_data only changes on an
   // accepted read, so writes and clears never disturb what DAT_I shows.
   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         state     <= CLEAR;
         clear_cnt <= '0;
         rd_data   <= '0;
      end else begin
         state     <= state_next;
         clear_cnt <= clear_cnt_next;
         if (rd_en) begin
            rd_data <= mem[bus.ADR_O];
         end
      end
   end

   // Tile storage has no reset; its contents only become defined through
   // the clear engine or bus writes. A single write port is shared between
   // the clear sweep and the bus, which never both want it in one cycle.
   always_ff @(posedge CLK_I) begin
      if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
   end

   // Next-state and write-port steering. In CLEAR one cell is written per
   // cycle and the sweep ends after cell 255 (the counter wraps back to 0
   // by itself). In IDLE a clear request beats a simultaneous bus request;
   // the bus request is left pending and picked up once the sweep is done.
   // ACK always lasts exactly one cycle, so a strobe still held high there
   // is not mistaken for a new request.
   always_comb begin
      state_next     = state;
      clear_cnt_next = clear_cnt;
      mem_we         = 1'b0;
      mem_addr       = bus.ADR_O;
      mem_wdata      = bus.DAT_O;
      rd_en          = 1'b0;
      case (state)
         CLEAR: begin
            mem_we         = 1'b1;
            mem_addr       = clear_cnt;
            mem_wdata      = INIT_VAL;
            clear_cnt_next = clear_cnt + ADDR_W'(1);
            if (clear_cnt == {ADDR_W{1'b1}}) begin
               state_next = IDLE;
            end
         end
         IDLE: begin
            if (clear_req) begin
               state_next     = CLEAR;
               clear_cnt_next = '0;
            end else if (bus.CYC_O && bus.STB_O) begin
               state_next = ACK;
               if (bus.WE_O) begin
                  mem_we = 1'b1;
               end else begin
                  rd_en = 1'b1;
               end
            end
         end
         ACK: begin
            state_next = IDLE;
         end
         default: begin
            state_next     = CLEAR;
            clear_cnt_next = '0;
         end
      endcase
   end

   // Outputs are decoded straight from the state so they take their reset
   // values the instant RST_I rises.
   assign bus.ACK_I = (state == ACK);
   assign bus.DAT_I = rd_data;
   assign busy      = (state == CLEAR);

endmodule

// File: tb/tb_board_mem_slave.sv
// Directed testbench for board_mem_slave: reset/clear timing, single and
// back-to-back transfers, clear/request arbitration, reset mid-clear and
// clear requests arriving during ACK.
module tb_board_mem_slave;

   logic CLK_I;
   logic RST_I;
   logic clear_req;
   logic busy;
   int   checks;
   int   bad;

   board_mem_slave_if #(.ADDR_W(8), .DATA_W(8)) bus ();

   board_mem_slave #(
      .ADDR_W   (8),
      .DATA_W   (8),
      .INIT_VAL (8'h00)
   ) dut (
      .CLK_I     (CLK_I),
      .RST_I     (RST_I),
      .bus       (bus),
      .clear_req (clear_req),
      .busy      (busy)
   );

   // Free-running 100 MHz clock.
   initial begin
      CLK_I = 1'b0;
      forever #5 CLK_I = ~CLK_I;
   end

   // Advance one clock edge and settle; outputs are sampled 1 time unit
   // after the rising edge and inputs are changed at the same point.
   task automatic tick();
      @(posedge CLK_I);
      #1;
   endtask

   task automatic bus_idle();
      bus.CYC_O = 1'b0;
      bus.STB_O = 1'b0;
      bus.WE_O  = 1'b0;
      bus.ADR_O = 8'h00;
      bus.DAT_O = 8'h00;
   endtask

   // Present one request, wait (bounded) for ACK_I, capture DAT_I in the
   // ACK cycle and drop the strobe. lat counts edges until ACK_I is seen.
   task automatic do_xfer(input logic we, input logic [7:0] adr,
                          input logic [7:0] dat,
                          output logic [7:0] rdata, output int lat);
      bus.CYC_O = 1'b1;
      bus.STB_O = 1'b1;
      bus.WE_O  = we;
      bus.ADR_O = adr;
      bus.DAT_O = dat;
      lat = 0;
      while (bus.ACK_I !== 1'b1 && lat < 600) begin
         tick();
         lat++;
      end
      rdata = bus.DAT_I;
      bus_idle();
   endtask

   // Count edges until busy falls, bounded.
   task automatic count_busy(output int n);
      n = 0;
      while (busy !== 1'b0 && n < 600) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      logic [7:0] rd;
      int         lat;
      int         n;
      logic [7:0] addrs [3];
      RST_I     = 1'b1;
      clear_req = 1'b0;
      bus_idle();
      #3;
      checks++;
      if (bus.ACK_I !== 1'b0) begin
         bad++; $display("[TB] FAIL reset_ack got=%b exp=0", bus.ACK_I);
      end
      checks++;
      if (bus.DAT_I !== 8'h00) begin
         bad++; $display("[TB] FAIL reset_dat got=%h exp=00", bus.DAT_I);
      end
      checks++;
      if (busy !== 1'b1) begin
         bad++; $display("[TB] FAIL reset_busy got=%b exp=1", busy);
      end
      tick();
      tick();
      RST_I = 1'b0;
      count_busy(n);
      checks++;
      if (n !== 256) begin
         bad++; $display("[TB] FAIL reset_clear_len got=%0d exp=256", n);
      end
      addrs[0] = 8'h00;
      addrs[1] = 8'h7F;
      addrs[2] = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         do_xfer(1'b0, addrs[i], 8'h00, rd, lat);
         checks++;
         if (rd !== 8'h00 || lat !== 1) begin
            bad++;
            $display("[TB] FAIL cleared_read adr=%h got=%h lat=%0d exp=00 lat=1",
                     addrs[i], rd, lat);
         end
         tick();
      end
   endtask

   task automatic test_write_read();
      logic [7:0] rd;
      int         lat;
      do_xfer(1'b1, 8'h12, 8'hA5, rd, lat);
      checks++;
      if (lat !== 1) begin
         bad++; $display("[TB] FAIL write_latency got=%0d exp=1", lat);
      end
      tick();
      checks++;
      if (bus.ACK_I !== 1'b0) begin
         bad++; $display("[TB] FAIL write_ack_width got=%b exp=0", bus.ACK_I);
      end
      do_xfer(1'b0, 8'h12, 8'h00, rd, lat);
      checks++;
      if (rd !== 8'hA5 || lat !== 1) begin
         bad++; $display("[TB] FAIL read_back got=%h lat=%0d exp=a5 lat=1", rd, lat);
      end
      tick();
      checks++;
      if (bus.ACK_I !== 1'b0 || bus.DAT_I !== 8'hA5) begin
         bad++;
         $display("[TB] FAIL read_ack_width ack=%b dat=%h exp ack=0 dat=a5",
                  bus.ACK_I, bus.DAT_I);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] rd;
      logic [7:0] exp_data;
      int         lat;
      logic       exp_ack;
      bus.CYC_O = 1'b1;
      bus.STB_O = 1'b1;
      bus.WE_O  = 1'b1;
      bus.ADR_O = 8'h20;
      bus.DAT_O = 8'hE0;
      for (int i = 0; i < 6; i++) begin
         exp_ack = (i % 2 == 1);
         checks++;
         if (bus.ACK_I !== exp_ack) begin
            bad++;
            $display("[TB] FAIL b2b_ack cycle=%0d got=%b exp=%b", i, bus.ACK_I, exp_ack);
         end
         if (bus.ACK_I === 1'b1) begin
            bus.ADR_O = bus.ADR_O + 8'd1;
            bus.DAT_O = bus.ADR_O ^ 8'hC0;
         end
         tick();
      end
      bus_idle();
      for (int a = 8'h20; a <= 8'h23; a++) begin
         exp_data = (a == 8'h23) ? 8'h00 : (8'(a) ^ 8'hC0);
         do_xfer(1'b0, 8'(a), 8'h00, rd, lat);
         checks++;
         if (rd !== exp_data) begin
            bad++;
            $display("[TB] FAIL b2b_readback adr=%h got=%h exp=%h", 8'(a), rd, exp_data);
         end
         tick();
      end
   endtask

   task automatic test_clear_with_request();
      logic [7:0] rd;
      int         lat;
      clear_req = 1'b1;
      bus.CYC_O = 1'b1;
      bus.STB_O = 1'b1;
      bus.WE_O  = 1'b0;
      bus.ADR_O = 8'h12;
      tick();
      clear_req = 1'b0;
      checks++;
      if (busy !== 1'b1 || bus.ACK_I !== 1'b0) begin
         bad++;
         $display("[TB] FAIL clear_wins busy=%b ack=%b exp busy=1 ack=0", busy, bus.ACK_I);
      end
      do_xfer(1'b0, 8'h12, 8'h00, rd, lat);
      checks++;
      if (lat !== 257) begin
         bad++; $display("[TB] FAIL stalled_read_wait got=%0d exp=257", lat);
      end
      checks++;
      if (rd !== 8'h00) begin
         bad++; $display("[TB] FAIL stalled_read_data got=%h exp=00", rd);
      end
      tick();
   endtask

   task automatic test_reset_mid_clear();
      logic [7:0] rd;
      int         lat;
      int         n;
      do_xfer(1'b1, 8'h30, 8'h5A, rd, lat);
      tick();
      do_xfer(1'b0, 8'h30, 8'h00, rd, lat);
      checks++;
      if (rd !== 8'h5A) begin
         bad++; $display("[TB] FAIL pre_clear_read got=%h exp=5a", rd);
      end
      tick();
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      repeat (100) tick();
      checks++;
      if (busy !== 1'b1 || bus.DAT_I !== 8'h5A) begin
         bad++;
         $display("[TB] FAIL mid_clear busy=%b dat=%h exp busy=1 dat=5a", busy, bus.DAT_I);
      end
      RST_I = 1'b1;
      #1;
      checks++;
      if (bus.ACK_I !== 1'b0 || bus.DAT_I !== 8'h00 || busy !== 1'b1) begin
         bad++;
         $display("[TB] FAIL mid_clear_reset ack=%b dat=%h busy=%b exp 0 00 1",
                  bus.ACK_I, bus.DAT_I, busy);
      end
      tick();
      RST_I = 1'b0;
      count_busy(n);
      checks++;
      if (n !== 256) begin
         bad++; $display("[TB] FAIL restart_clear_len got=%0d exp=256", n);
      end
      do_xfer(1'b0, 8'h30, 8'h00, rd, lat);
      checks++;
      if (rd !== 8'h00 || lat !== 1) begin
         bad++; $display("[TB] FAIL recleared_read got=%h lat=%0d exp=00 lat=1", rd, lat);
      end
      tick();
   endtask

   task automatic test_clear_in_ack();
      logic [7:0] rd;
      int         lat;
      do_xfer(1'b1, 8'h40, 8'h33, rd, lat);
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      checks++;
      if (busy !== 1'b0 || bus.ACK_I !== 1'b0) begin
         bad++;
         $display("[TB] FAIL clear_in_ack busy=%b ack=%b exp busy=0 ack=0", busy, bus.ACK_I);
      end
      tick();
      checks++;
      if (busy !== 1'b0) begin
         bad++; $display("[TB] FAIL clear_ignored got=%b exp=0", busy);
      end
      do_xfer(1'b0, 8'h40, 8'h00, rd, lat);
      checks++;
      if (rd !== 8'h33 || lat !== 1) begin
         bad++; $display("[TB] FAIL write_kept got=%h lat=%0d exp=33 lat=1", rd, lat);
      end
      tick();
   endtask

   initial begin
      checks = 0;
      bad    = 0;
      test_reset();
      test_write_read();
      test_back_to_back();
      test_clear_with_request();
      test_reset_mid_clear();
      test_clear_in_ack();
      $display("test done: total=%0d bad=%0d", checks, bad);
      $finish;
   end

endmodule
